// File: rtl/mem_ctrl_top_if.sv
// Wishbone-classic bus bundle between the host and the unified instruction/data RAM.
interface mem_ctrl_top_if;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [31:0] ADR_I;

  modport master (output we, stb, cyc, DAT_I, ADR_I, input ack, DAT_O);
  modport slave  (input we, stb, cyc, DAT_I, ADR_I, output ack, DAT_O);
endinterface

// File: rtl/mem_ctrl_top.sv
// Wishbone-classic slave in front of the unified RAM; two-cycle accept/commit access.
// Optional RANGE_CHECK_EN: out-of-range addresses are acked, writes dropped, reads return DEADBEEF.
module mem_ctrl_top #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            core_select,
  mem_ctrl_top_if.slave   wb
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t          state_reg;
  logic [AW-1:0]   addr_reg;
  logic            we_reg;
  logic            ack_reg;
  logic [DW-1:0]   dat_o_reg;
  logic [DW-1:0]   mem [DEPTH];

  logic            req;
  logic            commit;
  logic            write_en;
  logic [DW-1:0]   rd_data;
  logic            unused_adr;

  assign req    = wb.stb & wb.cyc & ~core_select;
  // The access only takes effect if the request is still held on the edge after the ack.
  assign commit = (state_reg == ACK) & req;

`ifdef RANGE_CHECK_EN
  logic oob_reg;
  logic req_oob;

  assign req_oob  = (wb.ADR_I >= 32'(DEPTH));
  assign write_en = commit & we_reg & ~oob_reg;
  assign rd_data  = oob_reg ? 32'hDEAD_BEEF : mem[addr_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_reg <= 1'b0;
    end else if (state_reg == IDLE && req) begin
      oob_reg <= req_oob;
    end
  end
`else
  assign write_en = commit & we_reg;
  assign rd_data  = mem[addr_reg];
`endif

  // Upper address bits are deliberately ignored so addresses wrap modulo DEPTH.
  assign unused_adr = ^wb.ADR_I[31:AW];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[addr_reg] <= wb.DAT_I;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      ack_reg   <= 1'b0;
      dat_o_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_reg  <= wb.ADR_I[AW-1:0];
            we_reg    <= wb.we;
            ack_reg   <= 1'b1;
            state_reg <= ACK;
          end else begin
            ack_reg   <= 1'b0;
          end
        end
        ACK: begin
          if (commit && !we_reg) begin
            dat_o_reg <= rd_data;
          end
          ack_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          ack_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign wb.ack   = ack_reg;
  assign wb.DAT_O = dat_o_reg;

endmodule

// File: tb/tb_mem_ctrl_top.sv
// Scoreboard bench for mem_ctrl_top: stimulus pushes expected acks/read data, a monitor pops and checks.
module tb_mem_ctrl_top;
  localparam int DEPTH = 128;

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic core_select = 1'b0;

  mem_ctrl_top_if bus();

  mem_ctrl_top #(.DEPTH(DEPTH), .AW(7), .DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .core_select (core_select),
    .wb          (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  bit          ref_vld [DEPTH];
  logic [31:0] last_read = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
`ifdef RANGE_CHECK_EN
    return a < DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!in_range(a)) return 32'hDEAD_BEEF;
    return ref_mem[a % DEPTH];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (in_range(a)) begin
      ref_mem[a % DEPTH] = d;
      ref_vld[a % DEPTH] = 1'b1;
    end
  endtask

  // mode: 0 normal, 1 drop cyc during ACK, 2 raise core_select during ACK, 3 reset during ACK
  task automatic wb_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input bit late, input int mode);
    exp_t e;
    int   n;
    e.is_read = !w;
    e.addr    = a;
    e.data    = w ? d : model_read(a);
    exp_q.push_back(e);
    bus.we    = w;
    bus.ADR_I = a;
    bus.DAT_I = late ? ~d : d;
    bus.stb   = 1'b1;
    bus.cyc   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack && n < 10);
    if (!bus.ack) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: addr %h got ack=0 for 10 cycles, required ack=1", a);
      void'(exp_q.pop_back());
      bus.stb = 1'b0;
      bus.cyc = 1'b0;
      return;
    end
    #2;
    bus.DAT_I = d;
    case (mode)
      1: bus.cyc = 1'b0;
      2: core_select = 1'b1;
      3: reset = 1'b0;
      default: ;
    endcase
    @(posedge clk);
    #1;
    bus.stb = 1'b0;
    bus.cyc = 1'b0;
    core_select = 1'b0;
    if (mode == 3) begin
      check("reset_mid_ack", {31'b0, bus.ack}, 32'h0);
      check("reset_mid_dato", bus.DAT_O, 32'h0);
      last_read = 32'h0;
      reset = 1'b1;
    end
    if (mode == 0) begin
      if (w) model_write(a, d);
      else last_read = e.data;
    end
  endtask

  task automatic read_known(input logic [31:0] a);
    wb_access(1'b0, a, 32'h0, 1'b0, 0);
  endtask

  // Monitor: each ack consumes one expected entry; read data is checked the cycle after ack.
  bit   prev_ack = 1'b0;
  bit   pend = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!reset) begin
      prev_ack = 1'b0;
      pend     = 1'b0;
    end else begin
      if (bus.ack) begin
        check("ack_consecutive", {31'b0, prev_ack}, 32'h0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: got ack=1 with no request pending, required ack=0");
        end else begin
          cur = exp_q.pop_front();
          $display("[TB] %s addr=%h data=%h", cur.is_read ? "RD" : "WR", cur.addr, cur.data);
          pend = cur.is_read;
        end
      end else if (pend) begin
        check("read_data", bus.DAT_O, cur.data);
        pend = 1'b0;
      end
      prev_ack = bus.ack;
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          idx;
    bus.we = 1'b0; bus.stb = 1'b0; bus.cyc = 1'b0;
    bus.DAT_I = 32'h0; bus.ADR_I = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;

    @(posedge clk);
    #1;
    check("reset_ack", {31'b0, bus.ack}, 32'h0);
    check("reset_dato", bus.DAT_O, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) wb_access(1'b1, i, 32'h1111_1111 * (i + 1), 1'b0, 0);
    for (int i = 0; i < 10; i++) read_known(i);
    for (int i = 10; i < 50; i++) wb_access(1'b1, i, $urandom, 1'($urandom_range(0, 1)), 0);

    // Bus held: cyc high, stb low
    bus.cyc = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("hold_ack", {31'b0, bus.ack}, 32'h0);
      check("hold_dato", bus.DAT_O, last_read);
    end
    @(posedge clk);
    #1;
    bus.cyc = 1'b0;

    for (int i = 50; i < 100; i++) wb_access(1'b1, i, $urandom, 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 100; i++) read_known(i);

    // Core owns the RAM: host write must be ignored
    core_select = 1'b1;
    bus.we = 1'b1; bus.ADR_I = 32'd5; bus.DAT_I = 32'hFFFF_FFFF;
    bus.stb = 1'b1; bus.cyc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("core_sel_ack", {31'b0, bus.ack}, 32'h0);
      check("core_sel_dato", bus.DAT_O, last_read);
    end
    bus.stb = 1'b0; bus.cyc = 1'b0;
    @(posedge clk);
    #1;
    core_select = 1'b0;
    read_known(5);

    wb_access(1'b1, 32'd130, 32'h1300_0130, 1'b0, 0);
    read_known(2);
    read_known(130);

    wb_access(1'b1, 32'd7, 32'h7777_0000, 1'b0, 1);
    read_known(7);
    wb_access(1'b1, 32'd8, 32'h8888_0000, 1'b0, 2);
    read_known(8);
    wb_access(1'b1, 32'd9, 32'h9999_0000, 1'b0, 3);
    read_known(9);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
        d = $urandom;
        wb_access(1'b1, a, d, 1'($urandom_range(0, 1)), 0);
      end else begin
        do idx = $urandom_range(0, DEPTH - 1); while (!ref_vld[idx]);
        a = ($urandom_range(0, 3) == 0) ? {25'($urandom), 7'(idx)} : 32'(idx);
        read_known(a);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
